digit_entry: RTL and testbench
==============================

# digit_entry

Debounced keypad-entry stage between the keypad scanner and the 4-digit 7-segment display driver. Takes raw scanned key codes and accepts exactly one key event per press. Digit keys shift into a 4-digit right-aligned entry register; clear and backspace keys edit it. The block drives the display's digit inputs plus a blanking mask for unused positions.

## Interface

- DEBOUNCE_TICKS, 20: consecutive ticks a code must be stable before it is accepted (1–255).
- RELEASE_TICKS, 20: consecutive ticks with no key required before a new press is armed (1–255).
- clk  in  1  system clock; the single clock for the block.
- reset  in  1  synchronous, active-high reset.
- tick  in  1  one-cycle scan-rate strobe (1 kHz); all debounce counting advances only on tick.
- key_valid  in  1  scanner reports a key is down.
- key_code  in  4  scanner key code, valid when key_valid=1.
- digit1  out  4  leftmost digit (minutes tens).
- digit2  out  4  minutes ones.
- digit3  out  4  seconds tens.
- digit4  out  4  rightmost digit (seconds ones).
- blank  out  4  blank[3]=digit1 … blank[0]=digit4; 1 = position not yet entered.
- entry_count  out  3  number of entered digits, 0–4.
- key_event  out  1  one-cycle pulse when a press is accepted.
- key_last  out  4  code of the most recently accepted key.

## Operation

- Debounce FSM states:
  - IDLE: if key_valid on tick → DEBOUNCE, latch key_code, cnt=1.
  - DEBOUNCE, on tick:
    - !key_valid → IDLE.
    - key_code ≠ latched → relatch, cnt=1.
    - Otherwise cnt++; when cnt reaches DEBOUNCE_TICKS → HELD and accept.
  - HELD: on tick, if !key_valid → RELEASE, cnt=1. Code changes while held are ignored (no rollover).
  - RELEASE, on tick:
    - key_valid → HELD (bounce, no new event).
    - Otherwise cnt++; when cnt reaches RELEASE_TICKS → IDLE.
- Accepted key actions:
  - 0x0–0x9: shift left (digit1←digit2←digit3←digit4←code); entry_count saturates at 4. Once full, the oldest digit is discarded.
  - 0xA CLEAR: all digits 0, entry_count=0.
  - 0xB BACKSPACE: shift right (digit4←digit3…, digit1←0); entry_count saturates at 0. At count 0, digits are unchanged.
  - 0xC–0xF: no register change. key_event still pulses and key_last updates.
- Blank mask: blank[i]=1 for the positions left of the entered digits. Formally, blank = 4'b1111 << entry_count, truncated to 4 bits, so count 0 → 1111, count 2 → 1100, count 4 → 0000.
- Signals outside tick cycles are ignored; the FSM and counter hold their values.

## Timing

- Reset values: digits 0, entry_count 0, blank 4'b1111, key_event 0, key_last 0, FSM IDLE, cnt 0.
- Press latency: a code presented stable from tick k is accepted on tick k+DEBOUNCE_TICKS−1. Digits, entry_count, blank, key_last and key_event update together on the clk edge after that tick cycle (one-cycle registered latency).
- key_event is high for exactly one clk cycle per press, never during reset.
- Reset mid-debounce or while HELD: the FSM returns to IDLE and no event fires. A key still held after reset deasserts is treated as a new press and must be debounced again.
- tick and reset in the same cycle: reset wins.
- Minimum press-to-press interval: DEBOUNCE_TICKS + RELEASE_TICKS ticks.

## Structure

- Package digit_entry_pkg:
  - FSM state enum (IDLE, DEBOUNCE, HELD, RELEASE).
  - Constants KEY_CLEAR=4'hA and KEY_BKSP=4'hB.
  - Digit width 4 and digit count 4.
- Sub-module key_debounce: FSM plus counter. Outputs an accept pulse and the accepted code.
- digit_entry: holds the edit/shift register, count and blank logic, and instantiates key_debounce.

## Test plan

- Reset, then press 0x5 stable for 20 ticks → key_event once after tick 20; digit4=5, entry_count=1, blank=1110; holding 200 more ticks gives no further event.
- Bounce: code 0x3 toggles key_valid every 5 ticks for 40 ticks, then stays stable → exactly one event, after 20 stable ticks.
- Enter 1,2,3,4,5 (full release between presses) → digits 2,3,4,5; entry_count=4; blank=0000.
- From digits 0,0,1,2 with count 2: BACKSPACE → digits 0,0,0,1, count 1, blank=1110; CLEAR → all 0, count 0, blank=1111; BACKSPACE at count 0 → no change, key_event pulses.
- Code changes from 0x7 to 0x8 at debounce tick 10 → 0x8 is accepted 20 ticks after the change and 0x7 never is. Code changes while HELD → ignored.
- Assert reset at debounce tick 15 with the key still held → no event; after reset releases, the press is accepted 20 ticks later.

Source files
------------

// File: rtl/digit_entry_pkg.sv
// Shared types and constants for the keypad digit-entry stage.
package digit_entry_pkg;

    localparam int DIGIT_W    = 4;
    localparam int NUM_DIGITS = 4;
    localparam int COUNT_W    = 3;
    localparam int CNT_W      = 8;

    localparam logic [DIGIT_W-1:0] KEY_MAX_DIGIT = 4'h9;
    localparam logic [DIGIT_W-1:0] KEY_CLEAR     = 4'hA;
    localparam logic [DIGIT_W-1:0] KEY_BKSP      = 4'hB;

    typedef enum logic [1:0] {
        IDLE,
        DEBOUNCE,
        HELD,
        RELEASE
    } deb_state_e;

    // Index NUM_DIGITS-1 is the leftmost display position.
    typedef logic [NUM_DIGITS-1:0][DIGIT_W-1:0] digits_t;

    // Positions left of the entered digits are blanked.
    function automatic logic [NUM_DIGITS-1:0] blank_mask(input logic [COUNT_W-1:0] count);
        logic [2*NUM_DIGITS-1:0] m;
        m = {{NUM_DIGITS{1'b0}}, {NUM_DIGITS{1'b1}}} << count;
        return m[NUM_DIGITS-1:0];
    endfunction

endpackage

// File: rtl/digit_entry_debounce.sv
// Press/release debouncer: emits one accept pulse per stable press, re-arms
// only after a stable release.
module key_debounce
    import digit_entry_pkg::*;
#(
    parameter int DEBOUNCE_TICKS = 20,
    parameter int RELEASE_TICKS  = 20
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               tick,
    input  logic               key_valid,
    input  logic [DIGIT_W-1:0] key_code,
    output logic               accept,
    output logic [DIGIT_W-1:0] accept_code
);

    localparam logic [CNT_W-1:0] DB_LIM  = CNT_W'(DEBOUNCE_TICKS);
    localparam logic [CNT_W-1:0] REL_LIM = CNT_W'(RELEASE_TICKS);

    deb_state_e         state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [DIGIT_W-1:0] code_q, code_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            code_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            code_q  <= code_d;
        end
    end

    // Limit checks use the updated count so a limit of 1 accepts/re-arms at once.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        code_d  = code_q;
        if (tick) begin
            unique case (state_q)
                IDLE: begin
                    if (key_valid) begin
                        code_d  = key_code;
                        cnt_d   = CNT_W'(1);
                        state_d = (cnt_d == DB_LIM) ? HELD : DEBOUNCE;
                    end
                end
                DEBOUNCE: begin
                    if (!key_valid) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end else begin
                        if (key_code != code_q) begin
                            code_d = key_code;
                            cnt_d  = CNT_W'(1);
                        end else begin
                            cnt_d  = cnt_q + CNT_W'(1);
                        end
                        if (cnt_d == DB_LIM) state_d = HELD;
                    end
                end
                HELD: begin
                    if (!key_valid) begin
                        cnt_d   = CNT_W'(1);
                        state_d = (cnt_d == REL_LIM) ? IDLE : RELEASE;
                    end
                end
                RELEASE: begin
                    if (key_valid) begin
                        state_d = HELD;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                        if (cnt_d == REL_LIM) state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
            if (state_d == IDLE) cnt_d = '0;
        end
    end

    // Entering HELD from RELEASE is a bounce, not a new press.
    always_comb begin
        accept      = !reset && (state_d == HELD) &&
                      (state_q == IDLE || state_q == DEBOUNCE);
        accept_code = code_d;
    end

endmodule

// File: rtl/digit_entry.sv
// Keypad entry register: digits shift in from the right, with clear and
// backspace editing, feeding a 4-digit display with a blanking mask.
module digit_entry
    import digit_entry_pkg::*;
#(
    parameter int DEBOUNCE_TICKS = 20,
    parameter int RELEASE_TICKS  = 20
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  tick,
    input  logic                  key_valid,
    input  logic [DIGIT_W-1:0]    key_code,
    output logic [DIGIT_W-1:0]    digit1,
    output logic [DIGIT_W-1:0]    digit2,
    output logic [DIGIT_W-1:0]    digit3,
    output logic [DIGIT_W-1:0]    digit4,
    output logic [NUM_DIGITS-1:0] blank,
    output logic [COUNT_W-1:0]    entry_count,
    output logic                  key_event,
    output logic [DIGIT_W-1:0]    key_last
);

    logic               accept;
    logic [DIGIT_W-1:0] accept_code;

    digits_t            digits_q, digits_d;
    logic [COUNT_W-1:0] count_q, count_d;
    logic               key_event_q, key_event_d;
    logic [DIGIT_W-1:0] key_last_q, key_last_d;

    key_debounce #(
        .DEBOUNCE_TICKS(DEBOUNCE_TICKS),
        .RELEASE_TICKS (RELEASE_TICKS)
    ) u_debounce (
        .clk        (clk),
        .reset      (reset),
        .tick       (tick),
        .key_valid  (key_valid),
        .key_code   (key_code),
        .accept     (accept),
        .accept_code(accept_code)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            digits_q    <= '0;
            count_q     <= '0;
            key_event_q <= 1'b0;
            key_last_q  <= '0;
        end else begin
            digits_q    <= digits_d;
            count_q     <= count_d;
            key_event_q <= key_event_d;
            key_last_q  <= key_last_d;
        end
    end

    always_comb begin
        digits_d    = digits_q;
        count_d     = count_q;
        key_event_d = accept;
        key_last_d  = key_last_q;
        if (accept) begin
            key_last_d = accept_code;
            if (accept_code <= KEY_MAX_DIGIT) begin
                // Once full, the leftmost digit falls off.
                digits_d = {digits_q[NUM_DIGITS-2:0], accept_code};
                if (count_q < COUNT_W'(NUM_DIGITS)) count_d = count_q + COUNT_W'(1);
            end else if (accept_code == KEY_CLEAR) begin
                digits_d = '0;
                count_d  = '0;
            end else if (accept_code == KEY_BKSP) begin
                if (count_q != '0) begin
                    digits_d = {{DIGIT_W{1'b0}}, digits_q[NUM_DIGITS-1:1]};
                    count_d  = count_q - COUNT_W'(1);
                end
            end
        end
    end

    assign digit1      = digits_q[3];
    assign digit2      = digits_q[2];
    assign digit3      = digits_q[1];
    assign digit4      = digits_q[0];
    assign entry_count = count_q;
    assign blank       = blank_mask(count_q);
    assign key_event   = key_event_q;
    assign key_last    = key_last_q;

endmodule

// File: tb/tb_digit_entry.sv
// Randomized bench for digit_entry against a press-level reference model.
module tb_digit_entry;

    localparam int DB = 20;
    localparam int RL = 20;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       tick = 1'b0;
    logic       key_valid = 1'b0;
    logic [3:0] key_code = '0;
    logic [3:0] digit1, digit2, digit3, digit4, blank, key_last;
    logic [2:0] entry_count;
    logic       key_event;

    digit_entry #(.DEBOUNCE_TICKS(DB), .RELEASE_TICKS(RL)) dut (
        .clk        (clk),
        .reset      (reset),
        .tick       (tick),
        .key_valid  (key_valid),
        .key_code   (key_code),
        .digit1     (digit1),
        .digit2     (digit2),
        .digit3     (digit3),
        .digit4     (digit4),
        .blank      (blank),
        .entry_count(entry_count),
        .key_event  (key_event),
        .key_last   (key_last)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: a press needs DB consecutive ticks of one code while
    // armed; re-arming needs RL consecutive key-free ticks.
    bit armed;
    int cand, run, gap, last_key;
    int ent[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        armed = 1; cand = 0; run = 0; gap = 0; last_key = 0;
        ent.delete();
    endtask

    task automatic model_apply(input int code);
        last_key = code;
        if (code < 10) begin
            ent.push_back(code);
            if (ent.size() > 4) void'(ent.pop_front());
        end else if (code == 10) begin
            ent.delete();
        end else if (code == 11 && ent.size() > 0) begin
            void'(ent.pop_back());
        end
    endtask

    task automatic model_tick(input bit kv, input int code, output bit ev);
        ev = 0;
        if (armed) begin
            if (kv) begin
                if (run > 0 && code == cand) run++;
                else begin cand = code; run = 1; end
                if (run == DB) begin
                    armed = 0; gap = 0; ev = 1;
                    model_apply(cand);
                end
            end else run = 0;
        end else if (kv) gap = 0;
        else begin
            gap++;
            if (gap == RL) begin armed = 1; run = 0; end
        end
    endtask

    task automatic cyc(input bit rst, input bit tk, input bit kv, input logic [3:0] code);
        bit ev;
        logic [3:0] dg [4];
        logic [3:0] eb;
        ev = 0;
        reset = rst; tick = tk; key_valid = kv; key_code = code;
        if (rst) model_reset();
        else if (tk) model_tick(kv, int'(code), ev);
        @(posedge clk); #1;
        dg[0] = digit4; dg[1] = digit3; dg[2] = digit2; dg[3] = digit1;
        chk("key_event", 32'(key_event), 32'(ev));
        chk("key_last", 32'(key_last), 32'(last_key));
        chk("entry_count", 32'(entry_count), 32'(ent.size()));
        for (int p = 0; p < 4; p++) begin
            eb[p] = (p >= ent.size());
            chk($sformatf("digit%0d", 4 - p), 32'(dg[p]),
                (p < ent.size()) ? 32'(ent[ent.size() - 1 - p]) : 32'd0);
        end
        chk("blank", 32'(blank), 32'(eb));
    endtask

    // One tick period: an off-tick cycle with garbage inputs, then the tick.
    task automatic tk(input bit kv, input logic [3:0] code);
        cyc(0, 0, 1'($urandom_range(0, 1)), 4'($urandom));
        cyc(0, 1, kv, code);
    endtask

    task automatic hold(input logic [3:0] code, input int n);
        repeat (n) tk(1, code);
    endtask

    task automatic rel(input int n);
        repeat (n) tk(0, 4'($urandom));
    endtask

    task automatic press(input logic [3:0] code);
        hold(code, DB + 2);
        rel(RL + 2);
    endtask

    initial begin
        model_reset();
        cyc(1, 1, 1, 4'h5);
        cyc(1, 0, 0, 4'h0);

        hold(4'h5, DB);
        hold(4'h5, 200);
        rel(RL + 5);

        for (int i = 0; i < 40; i++) tk(((i / 5) % 2) == 0, 4'h3);
        hold(4'h3, DB + 5);
        rel(RL + 5);

        for (int i = 1; i <= 5; i++) press(4'(i));

        press(4'hA); press(4'h1); press(4'h2);
        press(4'hB); press(4'hA); press(4'hB);
        press(4'hC); press(4'h9); press(4'hF);

        hold(4'h7, 10);
        hold(4'h8, DB + 5);
        hold(4'h9, 10);
        rel(RL + 5);

        hold(4'h6, 15);
        cyc(1, 1, 1, 4'h6);
        hold(4'h6, DB + 5);
        rel(RL + 5);

        hold(4'h4, DB + 5);
        cyc(1, 1, 1, 4'h4);
        hold(4'h4, DB + 5);
        rel(RL + 5);

        // Boundary: release bounce exactly one tick short of re-arming.
        hold(4'h2, DB);
        rel(RL - 1);
        hold(4'h2, DB + 2);
        rel(RL);

        repeat (250) begin
            int r;
            r = $urandom_range(0, 19);
            if (r == 0) cyc(1, 1'($urandom_range(0, 1)), 1, 4'($urandom));
            else if (r < 8) rel($urandom_range(1, 30));
            else hold(4'($urandom_range(0, 15)), $urandom_range(1, 30));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
